// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types and defaults.
package rv32i_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned INSTR_BYTES  = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned IM_BYTES_DEF = 8192;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} pairs.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  // Flush takes priority; a full FIFO never accepts, an empty one never gives.
  assign do_push = push & ~flush & ~full;
  assign do_pop  = pop & ~flush & ~empty;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage, pointers and occupancy; storage is cleared so the head is never X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, memory address, redirect/fault control and output FIFO.
module fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int unsigned IM_BYTES = IM_BYTES_DEF,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] im_addr,
  input  logic [31:0] im_instr,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int unsigned     CW      = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] LAST_PC = XLEN'(IM_BYTES - INSTR_BYTES);

  logic [XLEN-1:0] pc;
  logic            pc_legal;
  logic            redirect;
  logic            push;
  logic            pop;
  logic [CW-1:0]   count;
  logic            empty;
  logic            unused_full;
  fetch_entry_t    din;
  fetch_entry_t    dout;

  assign pc_legal = (pc[1:0] == 2'b00) && (pc <= LAST_PC);
  assign redirect = redirect_valid & ~fault;
  // Push only when not full at the start of the cycle, so ready never depends on pop.
  assign push     = fetch_en & ~fault & ~redirect_valid & pc_legal & (count < CW'(DEPTH));
  assign pop      = out_valid & out_ready;

  assign im_addr   = pc;
  assign din       = '{pc: pc, instr: im_instr};
  assign out_valid = ~empty;
  assign out_pc    = dout.pc;
  assign out_instr = dout.instr;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (din),
    .dout  (dout),
    .count (count),
    .full  (unused_full),
    .empty (empty)
  );

  // PC advance, redirect and sticky fault capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (!fault && !pc_legal) begin
      fault    <= 1'b1;
      fault_pc <= pc;
    end else if (push) begin
      pc <= pc + XLEN'(INSTR_BYTES);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit.
module tb_fetch_unit;
  import rv32i_pkg::*;

  localparam int unsigned IMB   = 8192;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] im_addr;
  logic [31:0] im_instr;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fault;
  logic [31:0] fault_pc;

  logic [31:0] imem [IMB/4];
  assign im_instr = (im_addr < 32'(IMB)) ? imem[im_addr[12:2]] : 32'h0;

  fetch_unit #(.RESET_PC(32'h0), .IM_BYTES(IMB), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .im_addr        (im_addr),
    .im_instr       (im_instr),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural PC, fault state and expected FIFO contents.
  logic [31:0]  m_pc;
  bit           m_fault;
  logic [31:0]  m_fault_pc;
  bit           m_pop_block;
  fetch_entry_t sb [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] p);
    return (p % 4 == 0) && (p <= 32'(IMB - 4));
  endfunction

  task automatic model_reset();
    sb.delete();
    m_pc        = 32'h0;
    m_fault     = 1'b0;
    m_fault_pc  = 32'h0;
    m_pop_block = 1'b0;
  endtask

  // One clock of architectural behaviour given the inputs just driven.
  task automatic model_step();
    fetch_entry_t e;
    m_pop_block = redirect_valid && !m_fault;
    if (redirect_valid && !m_fault) begin
      sb.delete();
      m_pc = redirect_pc;
    end else if (!m_fault && !legal(m_pc)) begin
      m_fault    = 1'b1;
      m_fault_pc = m_pc;
    end else if (fetch_en && !m_fault && sb.size() < DEPTH) begin
      e.pc    = m_pc;
      e.instr = imem[int'(m_pc / 4)];
      sb.push_back(e);
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic do_reset();
    #1;
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    model_reset();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    chk("rst_im_addr", im_addr, 32'h0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Check status against the model, then drive the next cycle's inputs.
  task automatic step(input bit fe, input bit rdy, input bit rv, input logic [31:0] rpc);
    @(negedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("fault_pc", fault_pc, m_fault_pc);
    chk("im_addr", im_addr, m_pc);
    fetch_en       = fe;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    model_step();
  endtask

  // Monitor: pop the expected head whenever the DUT completes a handshake.
  initial begin
    fetch_entry_t exp;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && out_valid && out_ready && !m_pop_block) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got pc %h with nothing expected at %0t", out_pc, $time);
        end else begin
          exp = sb.pop_front();
          chk("out_pc", out_pc, exp.pc);
          chk("out_instr", out_instr, exp.instr);
        end
      end
    end
  end

  initial begin
    bit          rv;
    logic [31:0] rpc;
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    for (int i = 0; i < IMB / 4; i++) imem[i] = $urandom;
    imem[0] = 32'h0020_0093;
    imem[1] = 32'h0030_0113;
    imem[2] = 32'h0011_01B3;

    // Streaming from reset
    do_reset();
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Backpressure from reset, then drain
    do_reset();
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Redirect flushes a full FIFO holding 0x10/0x14
    do_reset();
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (2) step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h40);
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Misaligned redirect faults; later redirect ignored
    step(1'b1, 1'b1, 1'b1, 32'h42);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Running off the end of instruction memory
    do_reset();
    step(1'b1, 1'b1, 1'b1, 32'h1FF0);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);

    // Random traffic
    do_reset();
    repeat (3000) begin
      if (m_fault && $urandom_range(0, 7) == 0) do_reset();
      rv = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = $urandom;
        1:       rpc = 32'h1FE0 + 32'($urandom_range(0, 12)) * 32'd4;
        default: rpc = 32'($urandom_range(0, 2047)) << 2;
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rv, rpc);
    end

    // Asynchronous reset with a full FIFO and no consumer
    do_reset();
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0);
    do_reset();
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);

    @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
